// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: issues single-outstanding word fetches and buffers up to DEPTH
// {pc, instr} entries. On a redirect the queue is flushed and fetching restarts at the new pc.
// If a request is still in flight when the redirect arrives, its data is dropped when it returns.

`ifndef WORDSIZE
`define WORDSIZE 16
`endif

module ifetch_queue #(
   parameter int unsigned    N        = `WORDSIZE,
   parameter int unsigned    DEPTH    = 4,
   parameter logic [N-1:0]   RESET_PC = '0
) (
   input  logic         clk,
   input  logic         reset,
   output logic         mem_req,
   output logic [N-1:0] mem_addr,
   input  logic         mem_ack,
   input  logic [N-1:0] mem_rdata,
   input  logic         redirect,
   input  logic [N-1:0] redirect_pc,
   output logic [N-1:0] instr,
   output logic [N-1:0] instr_pc,
   output logic         instr_valid,
   input  logic         instr_ready
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {StIdle, StWait, StDrop} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  fetch_pc_q, fetch_pc_d;
   logic [N-1:0]  pend_pc_q, pend_pc_d;
   logic          mem_req_q, mem_req_d;

   logic [N-1:0]  instr_mem_q [DEPTH];
   logic [N-1:0]  pc_mem_q    [DEPTH];
   logic [AW-1:0] head_q, tail_q;
   logic [CW-1:0] count_q, count_d;
   logic          valid_q;

   logic          pop;
   logic          push;
   logic [CW-1:0] cnt_n;

   assign pop   = valid_q & instr_ready;
   assign cnt_n = count_q - CW'(pop);
   // Only a live WAIT request ever delivers data; DROP data and redirect-edge data are discarded.
   assign push  = (state_q == StWait) & mem_ack & ~redirect;

   assign count_d = redirect ? '0 : (count_q + CW'(push) - CW'(pop));

   // Next-state and fetch/pending address selection.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      pend_pc_d  = pend_pc_q;
      unique case (state_q)
         StIdle: begin
            if (redirect) begin
               fetch_pc_d = redirect_pc;
               state_d    = StWait;
            end else if (cnt_n < DEPTH_C) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (mem_ack) begin
               if (redirect) begin
                  fetch_pc_d = redirect_pc;
               end else begin
                  fetch_pc_d = fetch_pc_q + N'(1);
                  // Keep fetching only if the pushed word still leaves a free slot.
                  state_d    = ((cnt_n + CW'(1)) < DEPTH_C) ? StWait : StIdle;
               end
            end else if (redirect) begin
               // Address must stay stable until the ack, so park the target.
               pend_pc_d = redirect_pc;
               state_d   = StDrop;
            end
         end
         StDrop: begin
            if (mem_ack) begin
               fetch_pc_d = redirect ? redirect_pc : pend_pc_q;
               state_d    = StWait;
            end else if (redirect) begin
               pend_pc_d = redirect_pc;
            end
         end
         default: state_d = StIdle;
      endcase
      mem_req_d = (state_d != StIdle);
   end

   // FSM state, fetch/pending pcs and the registered request strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         fetch_pc_q <= RESET_PC;
         pend_pc_q  <= '0;
         mem_req_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         pend_pc_q  <= pend_pc_d;
         mem_req_q  <= mem_req_d;
      end
   end

   // Queue pointers, occupancy and registered head-valid flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
      end else begin
         count_q <= count_d;
         valid_q <= (count_d != '0);
         if (redirect) begin
            head_q <= '0;
            tail_q <= '0;
         end else begin
            if (push) tail_q <= tail_q + AW'(1);
            if (pop)  head_q <= head_q + AW'(1);
         end
      end
   end

   // Entry storage; contents are only observed through the valid-gated head.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem_q[tail_q] <= mem_rdata;
         pc_mem_q[tail_q]    <= fetch_pc_q;
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_addr    = fetch_pc_q;
   assign instr_valid = valid_q;
   assign instr       = valid_q ? instr_mem_q[head_q] : '0;
   assign instr_pc    = valid_q ? pc_mem_q[head_q] : '0;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a cycle table plus hand-written redirect/wrap/reset sequences.
// Memory model: ack follows mem_req when ack_en is set; data is always mem_addr + 0x1000.

module tb_ifetch_queue;

   localparam int unsigned N     = 16;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          mem_req, mem_ack;
   logic [N-1:0]  mem_addr, mem_rdata;
   logic          redirect;
   logic [N-1:0]  redirect_pc;
   logic [N-1:0]  instr, instr_pc;
   logic          instr_valid, instr_ready;
   logic          ack_en;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign mem_ack   = mem_req & ack_en;
   assign mem_rdata = mem_addr + 16'h1000;

   ifetch_queue #(
      .N        (N),
      .DEPTH    (DEPTH),
      .RESET_PC (16'h0000)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready)
   );

   // No push into a full queue and no pop from an empty one.
   always @(posedge clk) begin
      if (!reset) begin
         assert (!(dut.push && (dut.count_q == 3'(DEPTH)) && !dut.pop)) else begin
            n_err++;
            $display("FAIL push_full: push with count=%0d", dut.count_q);
         end
         assert (!(dut.pop && (dut.count_q == 3'd0))) else begin
            n_err++;
            $display("FAIL pop_empty: pop with count=%0d", dut.count_q);
         end
      end
   end

   typedef struct {
      logic        rst, rdy, ack, rd;
      logic [15:0] rpc;
      logic        req;
      logic [15:0] addr;
      logic        v;
      logic [15:0] ipc, ins;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, rdy, ack, rd, input logic [15:0] rpc,
                      input logic req, input logic [15:0] addr, input logic v,
                      input logic [15:0] ipc, ins);
      vec_t t;
      t.rst = rst; t.rdy = rdy; t.ack = ack; t.rd = rd; t.rpc = rpc;
      t.req = req; t.addr = addr; t.v = v; t.ipc = ipc; t.ins = ins;
      tbl.push_back(t);
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk(input string tag, input logic req, input logic [15:0] addr,
                      input logic v, input logic [15:0] ipc, input logic [15:0] ins);
      check({tag, " mem_req"}, 16'(mem_req), 16'(req));
      check({tag, " mem_addr"}, mem_addr, addr);
      check({tag, " instr_valid"}, 16'(instr_valid), 16'(v));
      check({tag, " instr_pc"}, instr_pc, ipc);
      check({tag, " instr"}, instr, ins);
   endtask

   task automatic drive(input logic rdy, ack, rd, input logic [15:0] rpc);
      @(negedge clk);
      instr_ready = rdy;
      ack_en      = ack;
      redirect    = rd;
      redirect_pc = rpc;
      #1;
   endtask

   initial begin
      reset = 1'b1; instr_ready = 1'b0; ack_en = 1'b0; redirect = 1'b0; redirect_pc = '0;

      //   rst rdy ack rd rpc       req addr     v ipc      instr
      add(1, 0, 1, 0, 16'h0000,  0, 16'h0000, 0, 16'h0000, 16'h0000);
      add(0, 0, 1, 0, 16'h0000,  0, 16'h0000, 0, 16'h0000, 16'h0000);
      add(0, 0, 1, 0, 16'h0000,  1, 16'h0000, 0, 16'h0000, 16'h0000);
      add(0, 0, 1, 0, 16'h0000,  1, 16'h0001, 1, 16'h0000, 16'h1000);
      add(0, 0, 1, 0, 16'h0000,  1, 16'h0002, 1, 16'h0000, 16'h1000);
      add(0, 0, 1, 0, 16'h0000,  1, 16'h0003, 1, 16'h0000, 16'h1000);
      add(0, 0, 1, 0, 16'h0000,  0, 16'h0004, 1, 16'h0000, 16'h1000); // full, req drops
      add(0, 1, 1, 0, 16'h0000,  0, 16'h0004, 1, 16'h0000, 16'h1000); // one pop
      add(0, 0, 1, 0, 16'h0000,  1, 16'h0004, 1, 16'h0001, 16'h1001); // one refill at 4
      add(0, 0, 1, 0, 16'h0000,  0, 16'h0005, 1, 16'h0001, 16'h1001);
      add(0, 1, 0, 0, 16'h0000,  0, 16'h0005, 1, 16'h0001, 16'h1001);
      add(0, 1, 0, 0, 16'h0000,  1, 16'h0005, 1, 16'h0002, 16'h1002);
      add(0, 0, 1, 1, 16'h0010,  1, 16'h0005, 1, 16'h0003, 16'h1003); // redirect + ack @5
      add(0, 0, 0, 0, 16'h0000,  1, 16'h0010, 0, 16'h0000, 16'h0000); // flushed
      add(0, 1, 1, 0, 16'h0000,  1, 16'h0010, 0, 16'h0000, 16'h0000);
      add(0, 1, 1, 0, 16'h0000,  1, 16'h0011, 1, 16'h0010, 16'h1010);
      add(0, 1, 1, 0, 16'h0000,  1, 16'h0012, 1, 16'h0011, 16'h1011);
      add(1, 1, 1, 0, 16'h0000,  0, 16'h0000, 0, 16'h0000, 16'h0000); // async reset
      add(0, 1, 1, 0, 16'h0000,  0, 16'h0000, 0, 16'h0000, 16'h0000);
      add(0, 1, 1, 0, 16'h0000,  1, 16'h0000, 0, 16'h0000, 16'h0000);
      add(0, 1, 1, 0, 16'h0000,  1, 16'h0001, 1, 16'h0000, 16'h1000); // 1 per cycle
      add(0, 1, 1, 0, 16'h0000,  1, 16'h0002, 1, 16'h0001, 16'h1001);
      add(0, 1, 1, 0, 16'h0000,  1, 16'h0003, 1, 16'h0002, 16'h1002);

      foreach (tbl[i]) begin
         @(negedge clk);
         reset       = tbl[i].rst;
         instr_ready = tbl[i].rdy;
         ack_en      = tbl[i].ack;
         redirect    = tbl[i].rd;
         redirect_pc = tbl[i].rpc;
         #1;
         chk($sformatf("v%0d", i), tbl[i].req, tbl[i].addr, tbl[i].v, tbl[i].ipc, tbl[i].ins);
      end

      // Slow ack during redirect: old address held, its data dropped, then 0xFFFF wrap.
      @(negedge clk);
      reset = 1'b1; instr_ready = 1'b1; ack_en = 1'b0; redirect = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      drive(1, 0, 0, 16'h0000); chk("drop_w1", 1, 16'h0000, 0, 16'h0000, 16'h0000);
      drive(1, 0, 1, 16'h0040); chk("drop_w2", 1, 16'h0000, 0, 16'h0000, 16'h0000);
      drive(1, 0, 0, 16'h0000); chk("drop_w3", 1, 16'h0000, 0, 16'h0000, 16'h0000);
      drive(1, 1, 0, 16'h0000); chk("drop_ack", 1, 16'h0000, 0, 16'h0000, 16'h0000);
      drive(1, 1, 0, 16'h0000); chk("drop_new", 1, 16'h0040, 0, 16'h0000, 16'h0000);
      drive(1, 1, 1, 16'hFFFF); chk("drop_first", 1, 16'h0041, 1, 16'h0040, 16'h1040);
      drive(1, 1, 0, 16'h0000); chk("wrap_req", 1, 16'hFFFF, 0, 16'h0000, 16'h0000);
      drive(1, 1, 0, 16'h0000); chk("wrap_ffff", 1, 16'h0000, 1, 16'hFFFF, 16'h0FFF);
      drive(1, 1, 0, 16'h0000); chk("wrap_0000", 1, 16'h0001, 1, 16'h0000, 16'h1000);

      // Asynchronous reset mid-WAIT with three entries queued.
      @(negedge clk);
      reset = 1'b1; instr_ready = 1'b0; ack_en = 1'b1; redirect = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("pre_rst", 1, 16'h0003, 1, 16'h0000, 16'h1000);
      #1;
      reset = 1'b1;
      #1;
      chk("async_rst", 0, 16'h0000, 0, 16'h0000, 16'h0000);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_rel", 0, 16'h0000, 0, 16'h0000, 16'h0000);
      @(posedge clk);
      #1;
      chk("restart", 1, 16'h0000, 0, 16'h0000, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 The block SHALL have parameter N, default `WORDSIZE (16), meaning instruction and address width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning prefetch queue entries (power of two, at least 2).
REQ-003 The block SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high. Port `clk`, input, 1 bit: rising-edge clock for all state.
REQ-005 Port `reset`, input, 1 bit: asynchronous active-high reset.
REQ-006 Port `mem_req`, output, 1 bit: instruction-memory read request.
REQ-007 Port `mem_addr`, output, N bits: word address of the outstanding request.
REQ-008 Port `mem_ack`, input, 1 bit: memory returns data this cycle.
REQ-009 Port `mem_rdata`, input, N bits: instruction word, valid when mem_ack=1.
REQ-010 Port `redirect`, input, 1 bit: branch/jump taken; flush and refetch.
REQ-011 Port `redirect_pc`, input, N bits: new fetch address, valid when redirect=1.
REQ-012 Port `instr`, output, N bits: head-of-queue instruction presented to the datapath.
REQ-013 Port `instr_pc`, output, N bits: word address of `instr`.
REQ-014 Port `instr_valid`, output, 1 bit: the queue head is valid.
REQ-015 Port `instr_ready`, input, 1 bit: the datapath consumes the head this cycle.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE (no request), WAIT (request outstanding), DROP (outstanding request whose data is to be discarded).
REQ-017 mem_req SHALL be 1 exactly in WAIT and DROP, and mem_addr SHALL equal register fetch_pc.
REQ-018 While mem_req=1, mem_addr SHALL remain stable until the edge on which mem_ack=1; at most one request SHALL be outstanding.
REQ-019 A transfer SHALL complete on a rising edge with mem_req=1 and mem_ack=1; zero-wait acks (mem_ack in the first req cycle) SHALL be accepted.
REQ-020 pop SHALL be defined as instr_valid AND instr_ready; it removes the head on that edge.
REQ-021 cnt_n SHALL be defined as count - pop.
REQ-022 IDLE, no redirect: the FSM SHALL go to WAIT when cnt_n < DEPTH, otherwise stay in IDLE.
REQ-023 WAIT, ack, no redirect: the block SHALL push {fetch_pc, mem_rdata} and set fetch_pc := fetch_pc+1 (mod 2^N).
REQ-024 After the push in REQ-023, the FSM SHALL stay in WAIT when cnt_n+1 < DEPTH, otherwise go to IDLE; back-to-back fetch SHALL sustain 1 instruction per cycle with zero-wait memory.
REQ-025 WAIT, no ack, no redirect: the FSM SHALL hold all state.
REQ-026 Redirect in any state SHALL flush the queue (count := 0) on that edge; a simultaneous pop has no further effect.
REQ-027 Redirect in IDLE: fetch_pc := redirect_pc; next state WAIT.
REQ-028 Redirect in WAIT with ack: discard mem_rdata; fetch_pc := redirect_pc; stay in WAIT.
REQ-029 Redirect in WAIT without ack: pend_pc := redirect_pc; next state DROP; fetch_pc unchanged.
REQ-030 DROP: mem_rdata SHALL never be pushed.
REQ-031 DROP without ack, with redirect: pend_pc := redirect_pc.
REQ-032 DROP with ack: fetch_pc := (redirect ? redirect_pc : pend_pc); next state WAIT.
REQ-033 The queue SHALL be a circular buffer with wrapping head/tail pointers and count 0..DEPTH; simultaneous push and pop SHALL leave count unchanged.
REQ-034 instr_valid SHALL be (count != 0), driven from registers only; instr/instr_pc SHALL be the head entry when valid and 0 when empty.
REQ-035 Latency: with zero-wait memory, a word acked on edge k SHALL appear with instr_valid=1 after edge k.
REQ-036 By construction, no push SHALL occur while full and no pop while empty; the bench SHALL assert both.

Reset
REQ-037 Asserting reset SHALL asynchronously set state=IDLE, fetch_pc=RESET_PC, pend_pc=0, count=head=tail=0, mem_req=0, instr_valid=0, instr=0, instr_pc=0.
REQ-038 Reset mid-request SHALL abandon the request; any ack arriving while reset is high or in IDLE SHALL be ignored.
REQ-039 The first mem_req SHALL rise one cycle after the first edge with reset low.

Verification
REQ-040 Reset release, zero-wait memory returning mem_rdata=addr+0x1000, instr_ready=1 -> instr_pc sequence 0,1,2,3... at 1 per cycle; instr=0x1000,0x1001,...
REQ-041 instr_ready=0, zero-wait memory -> exactly 4 pushes (pcs 0-3), count=4, mem_req drops to 0.
REQ-042 After REQ-041, raise instr_ready for 1 cycle -> exactly one new request at address 4.
REQ-043 Memory ack delay of 3 cycles, redirect to 0x0040 in the 2nd wait cycle -> mem_addr holds the old address until its ack, that data is dropped, next mem_addr=0x0040, first instr_pc=0x0040.
REQ-044 Redirect to 0x0010 on the same edge as an ack for address 5, queue holding 2 entries -> queue empty after the edge, address-5 data never appears, next mem_addr=0x0010.
REQ-045 fetch_pc=0xFFFF with zero-wait memory -> instr_pc 0xFFFF then 0x0000.
REQ-046 Assert reset asynchronously mid-WAIT with 3 entries queued -> mem_req and instr_valid go low before the next clock edge; fetch restarts at RESET_PC.
